// File: rtl/moore_seq_player_pkg.sv
// moore_seq_player_pkg: state encoding and symbol constants shared by player, detector and bench
package moore_seq_player_pkg;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RST   = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [1:0] SYM_00 = 2'b00;
   localparam logic [1:0] SYM_01 = 2'b01;
   localparam logic [1:0] SYM_10 = 2'b10;
   localparam logic [1:0] SYM_11 = 2'b11;
   typedef enum logic [2:0] {
      IDLE  = S_IDLE,
      RST   = S_RST,
      PLAY  = S_PLAY,
      DRAIN = S_DRAIN,
      DONE  = S_DONE
   } state_t;
endpackage

// File: rtl/moore_sym_mem.sv
// moore_sym_mem: DEPTH x 2 symbol register file, one write port, one asynchronous read port
module moore_sym_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [1:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [1:0]    rdata_o
);
   logic [1:0] mem_q [DEPTH];
   // symbol storage; contents survive reset
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/moore_seq_player.sv
// moore_seq_player: plays a programmed symbol list into a Moore detector and traces its output
module moore_seq_player
   import moore_seq_player_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [1:0]       wr_sym_i,
   input  logic [AW:0]      len_i,
   input  logic [DIV_W-1:0] step_div_i,
   input  logic             start_i,
   input  logic             abort_i,
   output logic             det_reset_o,
   output logic [1:0]       det_ain_o,
   input  logic             det_yout_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [DEPTH-1:0] trace_o,
   output logic [AW:0]      rise_cnt_o
);
   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
   state_t             state_q, state_d;
   logic [AW-1:0]      idx_q, idx_d, pidx_q, pidx_d;
   logic [DIV_W-1:0]   hc_q, hc_d, div_q, div_d;
   logic [AW:0]        len_q, len_d, cnt_q, cnt_d;
   logic [DEPTH-1:0]   trace_q, trace_d;
   logic               pend_q, pend_d, yout_q;
   logic               det_reset_q, det_reset_d, ab;
   logic [1:0]         det_ain_q, det_ain_d, rd_sym;
   moore_sym_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk     (clk),
      .we_i    (wr_en_i && !busy_o),
      .waddr_i (wr_addr_i),
      .wdata_i (wr_sym_i),
      .raddr_i (idx_d),
      .rdata_o (rd_sym)
   );
   assign busy_o      = state_q inside {RST, PLAY, DRAIN};
   assign done_o      = state_q == DONE;
   assign ab          = abort_i && busy_o;
   assign det_reset_d = ab || state_d == RST;
   assign det_ain_d   = state_d == PLAY ? rd_sym : state_d == DRAIN ? det_ain_q : SYM_00;
   assign det_reset_o = det_reset_q;
   assign det_ain_o   = det_ain_q;
   assign trace_o     = trace_q;
   assign rise_cnt_o  = cnt_q;
   // next state: sequencing, hold counting, trace capture one cycle after each window, edge counting
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hc_d    = hc_q;
      div_d   = div_q;
      len_d   = len_q;
      trace_d = trace_q;
      cnt_d   = cnt_q;
      pend_d  = 1'b0;
      pidx_d  = pidx_q;
      if (pend_q) trace_d[pidx_q] = det_yout_i;
      if ((state_q == PLAY || state_q == DRAIN) && det_yout_i && !yout_q && cnt_q != '1)
         cnt_d = cnt_q + 1'b1;
      case (state_q)
         IDLE: if (start_i) begin
            state_d = RST;
            len_d   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
            div_d   = step_div_i;
            trace_d = '0;
            cnt_d   = '0;
         end
         RST: begin
            state_d = (len_q == '0) ? DRAIN : PLAY;
            idx_d   = '0;
            hc_d    = '0;
         end
         PLAY: if (hc_q == div_q) begin
            hc_d    = '0;
            pend_d  = 1'b1;
            pidx_d  = idx_q;
            state_d = ({1'b0, idx_q} == len_q - 1'b1) ? DRAIN : PLAY;
            idx_d   = ({1'b0, idx_q} == len_q - 1'b1) ? idx_q : idx_q + 1'b1;
         end else begin
            hc_d = hc_q + 1'b1;
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (ab) begin
         state_d = IDLE;
         pend_d  = 1'b0;
      end
   end
   // state and registered detector drive; reset re-arms the detector
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         hc_q        <= '0;
         div_q       <= '0;
         len_q       <= '0;
         trace_q     <= '0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         pidx_q      <= '0;
         yout_q      <= 1'b0;
         det_reset_q <= 1'b1;
         det_ain_q   <= SYM_00;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         hc_q        <= hc_d;
         div_q       <= div_d;
         len_q       <= len_d;
         trace_q     <= trace_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pidx_q      <= pidx_d;
         yout_q      <= det_yout_i;
         det_reset_q <= det_reset_d;
         det_ain_q   <= det_ain_d;
      end
   end
endmodule

// File: tb/tb_moore_seq_player.sv
// tb_moore_seq_player: directed checks of the sequencer driving a small Moore detector model
module tb_moore_seq_player;
   import moore_seq_player_pkg::*;
   logic        clk = 1'b0;
   logic        reset, wr_en_i, start_i, abort_i;
   logic [3:0]  wr_addr_i;
   logic [1:0]  wr_sym_i;
   logic [4:0]  len_i;
   logic [7:0]  step_div_i;
   logic        det_reset_o, det_yout_i, busy_o, done_o;
   logic [1:0]  det_ain_o;
   logic [15:0] trace_o;
   logic [4:0]  rise_cnt_o;
   logic [1:0]  ds = 2'd0;
   logic [1:0]  ain_log [0:511];
   logic [1:0]  prog [0:4] = '{SYM_11, SYM_00, SYM_00, SYM_01, SYM_00};
   int          npass = 0, ntot = 0, bc = 0;

   moore_seq_player dut (
      .clk(clk), .reset(reset), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_sym_i(wr_sym_i),
      .len_i(len_i), .step_div_i(step_div_i), .start_i(start_i), .abort_i(abort_i),
      .det_reset_o(det_reset_o), .det_ain_o(det_ain_o), .det_yout_i(det_yout_i),
      .busy_o(busy_o), .done_o(done_o), .trace_o(trace_o), .rise_cnt_o(rise_cnt_o)
   );

   always #5 clk = ~clk;

   // detector model: A -11-> B -00-> C -01-> D -00-> A; yout high in C and D
   always @(posedge clk) begin
      if (det_reset_o) ds <= 2'd0;
      else case (ds)
         2'd0: ds <= (det_ain_o == SYM_11) ? 2'd1 : 2'd0;
         2'd1: ds <= (det_ain_o == SYM_11) ? 2'd1 : (det_ain_o == SYM_00) ? 2'd2 : 2'd0;
         2'd2: ds <= (det_ain_o == SYM_00) ? 2'd2 : (det_ain_o == SYM_01) ? 2'd3 : (det_ain_o == SYM_11) ? 2'd1 : 2'd0;
         default: ds <= (det_ain_o == SYM_01) ? 2'd3 : (det_ain_o == SYM_11) ? 2'd1 : 2'd0;
      endcase
   end
   assign det_yout_i = ds[1];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wr(input int a, input logic [1:0] s);
      wr_en_i = 1'b1; wr_addr_i = a[3:0]; wr_sym_i = s;
      tick;
      wr_en_i = 1'b0;
   endtask

   task automatic go(input int l, input int d);
      len_i = l[4:0]; step_div_i = d[7:0]; start_i = 1'b1;
      tick;
      start_i = 1'b0;
   endtask

   task automatic finish_run(input int inj);
      bc = 0;
      while (busy_o && bc < 500) begin
         ain_log[bc] = det_ain_o;
         if (bc == inj) begin
            wr_en_i = 1'b1; wr_addr_i = 4'd0; wr_sym_i = SYM_10; start_i = 1'b1;
         end
         tick;
         wr_en_i = 1'b0; start_i = 1'b0;
         bc++;
      end
      chk("done_pulse", done_o, 1);
      chk("done_busy", busy_o, 0);
      tick;
      chk("done_drop", done_o, 0);
   endtask

   initial begin
      reset = 1'b1; wr_en_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      wr_addr_i = '0; wr_sym_i = '0; len_i = '0; step_div_i = '0;
      tick;
      chk("rst_det_reset", det_reset_o, 1);
      chk("rst_det_ain", det_ain_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_trace", trace_o, 0);
      chk("rst_rise", rise_cnt_o, 0);
      tick;
      reset = 1'b0;
      tick;
      chk("rel_det_reset", det_reset_o, 0);
      for (int i = 0; i < 5; i++) wr(i, prog[i]);
      for (int i = 5; i < 16; i++) wr(i, SYM_00);
      go(5, 0);
      finish_run(-1);
      chk("t1_busy_len", bc, 7);
      chk("t1_trace", trace_o, 16'h000E);
      chk("t1_rise", rise_cnt_o, 1);
      go(5, 2);
      finish_run(-1);
      chk("t2_busy_len", bc, 17);
      for (int k = 0; k < 17; k++)
         chk($sformatf("t2_ain_%0d", k), ain_log[k], (k == 0) ? SYM_00 : (k == 16) ? prog[4] : prog[(k-1)/3]);
      chk("t2_trace", trace_o, 16'h000E);
      chk("t2_rise", rise_cnt_o, 1);
      repeat (3) tick;
      chk("t2_trace_hold", trace_o, 16'h000E);
      go(0, 0);
      finish_run(-1);
      chk("t3_busy_len", bc, 2);
      chk("t3_trace", trace_o, 0);
      chk("t3_rise", rise_cnt_o, 0);
      go(5, 0);
      tick; tick; tick;
      chk("t4_at_idx2", det_ain_o, prog[2]);
      abort_i = 1'b1;
      tick;
      abort_i = 1'b0;
      chk("t4_ab_det_reset", det_reset_o, 1);
      chk("t4_ab_det_ain", det_ain_o, 0);
      chk("t4_ab_busy", busy_o, 0);
      chk("t4_ab_done", done_o, 0);
      chk("t4_ab_trace", trace_o, 16'h0002);
      chk("t4_ab_rise", rise_cnt_o, 1);
      tick;
      chk("t4_post_det_reset", det_reset_o, 0);
      chk("t4_post_done", done_o, 0);
      chk("t4_post_busy", busy_o, 0);
      go(5, 0);
      finish_run(-1);
      chk("t4_rerun_len", bc, 7);
      chk("t4_rerun_trace", trace_o, 16'h000E);
      go(5, 0);
      finish_run(3);
      chk("t5_busy_len", bc, 7);
      chk("t5_trace", trace_o, 16'h000E);
      go(5, 0);
      finish_run(-1);
      for (int k = 0; k < 5; k++) chk($sformatf("t5_readback_%0d", k), ain_log[k+1], prog[k]);
      len_i = 5'd5; step_div_i = 8'd0; start_i = 1'b1; abort_i = 1'b1;
      tick;
      start_i = 1'b0; abort_i = 1'b0;
      chk("sa_busy", busy_o, 1);
      chk("sa_det_reset", det_reset_o, 1);
      finish_run(-1);
      chk("sa_busy_len", bc, 7);
      go(20, 0);
      finish_run(-1);
      chk("clamp_busy_len", bc, 18);
      chk("clamp_trace", trace_o, 16'h000E);
      chk("clamp_rise", rise_cnt_o, 1);
      go(5, 0);
      tick; tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("t6_det_reset", det_reset_o, 1);
      chk("t6_det_ain", det_ain_o, 0);
      chk("t6_busy", busy_o, 0);
      chk("t6_done", done_o, 0);
      chk("t6_trace", trace_o, 0);
      chk("t6_rise", rise_cnt_o, 0);
      tick;
      chk("t6_post_det_reset", det_reset_o, 0);
      chk("t6_post_busy", busy_o, 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
